// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: takes one client command at a time and runs it as a
// locked, pipelined NONSEQ/SEQ burst, streaming write data in and read data out.
module ahb_burst_master #(
  parameter logic [3:0]  HPROT_VAL     = 4'b0011,
  parameter int unsigned GRANT_TIMEOUT = 64
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_burst,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] wdata,
  output logic        wdata_ack,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        done,
  output logic        done_err,
  output logic        hbusreq,
  input  logic        hgrant,
  output logic        hmastlock,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic        hresp
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'((GRANT_TIMEOUT == 0) ? 0 : GRANT_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_BURST, S_LAST} state_t;

  state_t        state;
  logic [4:0]    beats_left;
  logic [TW-1:0] wait_cnt;
  logic          lost;
  logic          write_q;
  logic [2:0]    burst_q;
  logic [31:0]   start_q;

  function automatic logic [4:0] beat_count(input logic [2:0] burst, input logic [4:0] len);
    case (burst)
      3'b000:         beat_count = 5'd1;
      3'b001:         beat_count = (len == 5'd0 || len > 5'd16) ? 5'd16 : len;
      3'b010, 3'b011: beat_count = 5'd4;
      3'b100, 3'b101: beat_count = 5'd8;
      default:        beat_count = 5'd16;
    endcase
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] burst);
    logic [31:0] mask;
    case (burst)
      3'b010:  mask = 32'h0000_000F;
      3'b100:  mask = 32'h0000_001F;
      3'b110:  mask = 32'h0000_003F;
      default: mask = 32'h0000_0000;
    endcase
    if (mask == 32'h0)
      next_addr = a + 32'd4;
    else
      next_addr = (a & ~mask) | ((a + 32'd4) & mask);
  endfunction

  assign hsize = 3'b010;

  // Combinational so the client can present the next beat before the following edge.
  assign wdata_ack = !hreset && write_q && hready &&
                     (state == S_ADDR || (state == S_BURST && !hresp));

  // Command capture (data only, no reset needed)
  always_ff @(posedge hclk) begin
    if (state == S_IDLE && cmd_valid && cmd_ready) begin
      write_q <= cmd_write;
      burst_q <= cmd_burst;
      start_q <= cmd_addr & ~32'h3;
    end
  end

  // Control FSM and registered bus outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      hbusreq     <= 1'b0;
      hmastlock   <= 1'b0;
      haddr       <= '0;
      htrans      <= TR_IDLE;
      hwrite      <= 1'b0;
      hburst      <= '0;
      hprot       <= '0;
      hwdata      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      beats_left  <= '0;
      wait_cnt    <= '0;
      lost        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
      hprot       <= HPROT_VAL;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            beats_left <= beat_count(cmd_burst, cmd_len) - 5'd1;
            wait_cnt   <= '0;
            lost       <= 1'b0;
            hbusreq    <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (hgrant && hready) begin
            state     <= S_ADDR;
            htrans    <= TR_NONSEQ;
            haddr     <= start_q;
            hwrite    <= write_q;
            hburst    <= burst_q;
            hmastlock <= 1'b1;
            wait_cnt  <= '0;
          end else if (GRANT_TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            hbusreq   <= 1'b0;
            done      <= 1'b1;
            done_err  <= 1'b1;
            cmd_ready <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_ADDR, S_BURST: begin
          if (hready) begin
            if (state == S_BURST && hresp) begin
              // Error on the previous beat: the address phase just taken is dropped.
              htrans    <= TR_IDLE;
              hmastlock <= 1'b0;
              hbusreq   <= 1'b0;
              done      <= 1'b1;
              done_err  <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              if (write_q)
                hwdata <= wdata;
              if (state == S_BURST && !write_q) begin
                rdata       <= hrdata;
                rdata_valid <= 1'b1;
              end
              if (beats_left == 5'd0 || !hgrant) begin
                htrans    <= TR_IDLE;
                hmastlock <= 1'b0;
                hbusreq   <= 1'b0;
                lost      <= (beats_left != 5'd0);
                state     <= S_LAST;
              end else begin
                htrans     <= TR_SEQ;
                haddr      <= next_addr(haddr, burst_q);
                beats_left <= beats_left - 5'd1;
                state      <= S_BURST;
              end
            end
          end
        end
        S_LAST: begin
          if (hready) begin
            if (!hresp && !write_q) begin
              rdata       <= hrdata;
              rdata_valid <= 1'b1;
            end
            done      <= 1'b1;
            done_err  <= hresp | lost;
            lost      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
